// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file constants and the MCU result FIFO entry layout.
// The constants are also used by the register file and the decoder.
package regfile_write_arbiter_pkg;

    localparam int REG_ADDR_W    = 4;
    localparam int DATA_W        = 32;
    localparam int NUM_BANK_REGS = 15;
    localparam logic [REG_ADDR_W-1:0] PC_ADDR = 4'd15;
    localparam int ENTRY_W       = REG_ADDR_W + DATA_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } mc_entry_t;

    // R15 lives outside the bank and is owned by the PC path.
    function automatic logic is_bank_reg(input logic [REG_ADDR_W-1:0] a);
        return a != PC_ADDR;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_sync_fifo.sv
// Synchronous FIFO with an extra pointer MSB that separates full from empty.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback (fixed priority) and
// buffered MCU results; tracks outstanding MCU destinations for hazard checks.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic                  WB_WE,
    input  logic [REG_ADDR_W-1:0] WB_A,
    input  logic [DATA_W-1:0]     WB_WD,
    input  logic                  MC_VALID,
    output logic                  MC_READY,
    input  logic [REG_ADDR_W-1:0] MC_A,
    input  logic [DATA_W-1:0]     MC_WD,
    input  logic                  MC_ISSUE,
    input  logic [REG_ADDR_W-1:0] MC_ISSUE_A,
    input  logic [REG_ADDR_W-1:0] Q1_A,
    input  logic [REG_ADDR_W-1:0] Q2_A,
    output logic                  HAZ1,
    output logic                  HAZ2,
    output logic                  STALL_REQ,
    output logic                  WE3,
    output logic [REG_ADDR_W-1:0] A3,
    output logic [DATA_W-1:0]     WD3,
    output logic [NUM_BANK_REGS-1:0] PEND,
    output logic                  ERR
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    mc_entry_t head, push_entry;
    logic      fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic      wb_wins, head_commit, head_drop, we3_arb;

    logic [CNT_W-1:0]         starve_q, starve_d;
    logic [NUM_BANK_REGS-1:0] pend_q, pend_d;
    logic                     err_q, err_d;
    logic [15:0]              pend_ext;

    assign push_entry = '{addr: MC_A, data: MC_WD};
    assign MC_READY   = RESETn && !fifo_full;
    assign fifo_push  = MC_VALID && MC_READY;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RESETn),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (push_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        wb_wins     = WB_WE && is_bank_reg(WB_A);
        fifo_pop    = !wb_wins && !fifo_empty;
        head_commit = fifo_pop && is_bank_reg(head.addr);
        head_drop   = fifo_pop && !is_bank_reg(head.addr);
        we3_arb     = 1'b0;
        A3          = '0;
        WD3         = '0;
        if (wb_wins) begin
            we3_arb = 1'b1;
            A3      = WB_A;
            WD3     = WB_WD;
        end else if (head_commit) begin
            we3_arb = 1'b1;
            A3      = head.addr;
            WD3     = head.data;
        end
    end

    // Reset gates the write enable combinationally so no write leaks out.
    assign WE3       = RESETn && we3_arb;
    assign STALL_REQ = (starve_q == CNT_MAX) && !fifo_empty;

    assign pend_ext = {1'b0, pend_q};
    assign PEND     = pend_q;
    assign ERR      = err_q;
    assign HAZ1     = is_bank_reg(Q1_A) && pend_ext[Q1_A];
    assign HAZ2     = is_bank_reg(Q2_A) && pend_ext[Q2_A];

    always_comb begin
        // Non-empty and not popping implies writeback took the port.
        starve_d = starve_q;
        if (fifo_empty || fifo_pop) begin
            starve_d = '0;
        end else if (starve_q != CNT_MAX) begin
            starve_d = starve_q + 1'b1;
        end

        err_d = err_q
              | (WB_WE && STALL_REQ)
              | head_drop
              | (MC_ISSUE && (!is_bank_reg(MC_ISSUE_A) || pend_ext[MC_ISSUE_A]));

        // Set is applied after clear so a same-cycle issue wins.
        pend_d = pend_q;
        for (int unsigned i = 0; i < NUM_BANK_REGS; i++) begin
            if (head_commit && head.addr == REG_ADDR_W'(i)) pend_d[i] = 1'b0;
            if (MC_ISSUE && MC_ISSUE_A == REG_ADDR_W'(i))   pend_d[i] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            starve_q <= '0;
            pend_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            starve_q <= starve_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences,
// and random traffic against a queue-based reference model.
module tb_regfile_write_arbiter;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 3;

    logic        CLK, RESETn;
    logic        WB_WE, MC_VALID, MC_READY, MC_ISSUE;
    logic [3:0]  WB_A, MC_A, MC_ISSUE_A, Q1_A, Q2_A, A3;
    logic [31:0] WB_WD, MC_WD, WD3;
    logic        HAZ1, HAZ2, STALL_REQ, WE3, ERR;
    logic [14:0] PEND;

    int n_cmp = 0;
    int n_err = 0;

    regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .WB_WE(WB_WE), .WB_A(WB_A), .WB_WD(WB_WD),
        .MC_VALID(MC_VALID), .MC_READY(MC_READY), .MC_A(MC_A), .MC_WD(MC_WD),
        .MC_ISSUE(MC_ISSUE), .MC_ISSUE_A(MC_ISSUE_A),
        .Q1_A(Q1_A), .Q2_A(Q2_A), .HAZ1(HAZ1), .HAZ2(HAZ2),
        .STALL_REQ(STALL_REQ), .WE3(WE3), .A3(A3), .WD3(WD3),
        .PEND(PEND), .ERR(ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- reference model ----------------
    typedef struct { logic [3:0] a; logic [31:0] d; } ent_t;
    ent_t q_m[$];
    bit   pend_m[15];
    int   cnt_m;
    bit   err_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        q_m.delete();
        foreach (pend_m[i]) pend_m[i] = 1'b0;
        cnt_m = 0;
        err_m = 1'b0;
    endtask

    function automatic bit m_haz(input logic [3:0] a);
        return (a != 4'd15) && pend_m[a];
    endfunction

    task automatic check_model();
        logic        e_we;
        logic [3:0]  e_a;
        logic [31:0] e_d;
        logic [14:0] e_p;
        e_we = 1'b0; e_a = '0; e_d = '0;
        if (WB_WE && WB_A != 4'd15) begin
            e_we = 1'b1; e_a = WB_A; e_d = WB_WD;
        end else if (q_m.size() > 0 && q_m[0].a != 4'd15) begin
            e_we = 1'b1; e_a = q_m[0].a; e_d = q_m[0].d;
        end
        for (int i = 0; i < 15; i++) e_p[i] = pend_m[i];
        chk("m_we3",   WE3,       e_we);
        chk("m_a3",    A3,        e_a);
        chk("m_wd3",   WD3,       e_d);
        chk("m_ready", MC_READY,  q_m.size() < DEPTH);
        chk("m_stall", STALL_REQ, (cnt_m == STARVE_LIMIT) && q_m.size() > 0);
        chk("m_haz1",  HAZ1,      m_haz(Q1_A));
        chk("m_haz2",  HAZ2,      m_haz(Q2_A));
        chk("m_pend",  PEND,      e_p);
        chk("m_err",   ERR,       err_m);
    endtask

    task automatic update_model();
        bit   wb_wins, stall, ready, popped;
        ent_t head, ne;
        wb_wins = WB_WE && WB_A != 4'd15;
        stall   = (cnt_m == STARVE_LIMIT) && q_m.size() > 0;
        ready   = q_m.size() < DEPTH;
        popped  = !wb_wins && q_m.size() > 0;
        if (WB_WE && stall) err_m = 1'b1;
        if (MC_ISSUE && (MC_ISSUE_A == 4'd15 || pend_m[MC_ISSUE_A])) err_m = 1'b1;
        if (q_m.size() == 0)  cnt_m = 0;
        else if (wb_wins)     cnt_m = (cnt_m < STARVE_LIMIT) ? cnt_m + 1 : cnt_m;
        else                  cnt_m = 0;
        if (popped) begin
            head = q_m.pop_front();
            if (head.a == 4'd15) err_m = 1'b1;
            else pend_m[head.a] = 1'b0;
        end
        if (MC_ISSUE && MC_ISSUE_A != 4'd15) pend_m[MC_ISSUE_A] = 1'b1;
        if (MC_VALID && ready) begin
            ne.a = MC_A; ne.d = MC_WD;
            q_m.push_back(ne);
        end
    endtask

    // Inputs are applied at the falling edge; checks land before the rising edge.
    task automatic tick();
        #2;
        check_model();
        @(posedge CLK);
        update_model();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        WB_WE = 0; WB_A = 0; WB_WD = 0;
        MC_VALID = 0; MC_A = 0; MC_WD = 0;
        MC_ISSUE = 0; MC_ISSUE_A = 0; Q1_A = 0; Q2_A = 4'd15;
    endtask

    task automatic do_reset();
        RESETn = 1'b0;
        idle_inputs();
        #1;
        model_reset();
        chk("rst_we3",   WE3,      1'b0);
        chk("rst_pend",  PEND,     15'h0);
        chk("rst_err",   ERR,      1'b0);
        chk("rst_ready", MC_READY, 1'b0);
        @(negedge CLK);
        RESETn = 1'b1;
    endtask

    // Fills the FIFO while writeback wins three times; leaves STALL_REQ=1.
    task automatic build_stall(input logic final_wb);
        idle_inputs();
        MC_VALID = 1; MC_A = 4'd1; MC_WD = 32'hA0;
        tick();
        for (int k = 1; k <= 3; k++) begin
            WB_WE = 1; WB_A = 4'd8; WB_WD = 32'(k);
            MC_VALID = 1; MC_A = 4'(k + 1); MC_WD = 32'hA0 + 32'(k);
            #1;
            if (k == 3) chk("stall_early", STALL_REQ, 1'b0);
            tick();
        end
        idle_inputs();
        WB_WE = final_wb; WB_A = 4'd8; WB_WD = 32'h88;
        #1;
        chk("full_ready", MC_READY,  1'b0);
        chk("full_stall", STALL_REQ, 1'b1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic wb_we; logic [3:0] wb_a; logic [31:0] wb_wd;
        logic mv; logic [3:0] ma; logic [31:0] md;
        logic iss; logic [3:0] ia; logic [3:0] q1;
        logic e_we; logic [3:0] e_a; logic [31:0] e_d;
        logic e_rdy; logic e_haz; logic e_stall; logic [14:0] e_pend; logic e_err;
    } vec_t;

    function automatic vec_t mk(
        logic wb_we, logic [3:0] wb_a, logic [31:0] wb_wd,
        logic mv, logic [3:0] ma, logic [31:0] md,
        logic iss, logic [3:0] ia, logic [3:0] q1,
        logic e_we, logic [3:0] e_a, logic [31:0] e_d,
        logic e_haz, logic [14:0] e_pend);
        vec_t v;
        v.wb_we = wb_we; v.wb_a = wb_a; v.wb_wd = wb_wd;
        v.mv = mv; v.ma = ma; v.md = md;
        v.iss = iss; v.ia = ia; v.q1 = q1;
        v.e_we = e_we; v.e_a = e_a; v.e_d = e_d;
        v.e_rdy = 1'b1; v.e_haz = e_haz; v.e_stall = 1'b0;
        v.e_pend = e_pend; v.e_err = 1'b0;
        return v;
    endfunction

    vec_t tbl[13];

    initial begin
        tbl[0]  = mk(0, 0, 0,     1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0,            0, 15'h0);
        tbl[1]  = mk(0, 0, 0,     0, 0, 0,            0, 0, 0, 1, 3, 32'hDEADBEEF, 0, 15'h0);
        tbl[2]  = mk(0, 0, 0,     0, 0, 0,            0, 0, 0, 0, 0, 0,            0, 15'h0);
        tbl[3]  = mk(0, 0, 0,     1, 7, 32'h22,       0, 0, 0, 0, 0, 0,            0, 15'h0);
        tbl[4]  = mk(1, 5, 32'h11, 0, 0, 0,           0, 0, 0, 1, 5, 32'h11,       0, 15'h0);
        tbl[5]  = mk(0, 0, 0,     0, 0, 0,            0, 0, 0, 1, 7, 32'h22,       0, 15'h0);
        tbl[6]  = mk(0, 0, 0,     0, 0, 0,            1, 2, 2, 0, 0, 0,            0, 15'h0);
        tbl[7]  = mk(0, 0, 0,     1, 2, 32'h55,       0, 0, 2, 0, 0, 0,            1, 15'h0004);
        tbl[8]  = mk(0, 0, 0,     0, 0, 0,            0, 0, 2, 1, 2, 32'h55,       1, 15'h0004);
        tbl[9]  = mk(0, 0, 0,     0, 0, 0,            0, 0, 2, 0, 0, 0,            0, 15'h0);
        tbl[10] = mk(0, 0, 0,     1, 9, 32'h99,       0, 0, 9, 0, 0, 0,            0, 15'h0);
        tbl[11] = mk(0, 0, 0,     0, 0, 0,            1, 9, 9, 1, 9, 32'h99,       0, 15'h0);
        tbl[12] = mk(0, 0, 0,     0, 0, 0,            0, 0, 9, 0, 0, 0,            1, 15'h0200);

        RESETn = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset_we3",   WE3,      1'b0);
        chk("reset_ready", MC_READY, 1'b0);
        chk("reset_pend",  PEND,     15'h0);
        RESETn = 1'b1;

        foreach (tbl[i]) begin
            WB_WE = tbl[i].wb_we; WB_A = tbl[i].wb_a; WB_WD = tbl[i].wb_wd;
            MC_VALID = tbl[i].mv; MC_A = tbl[i].ma; MC_WD = tbl[i].md;
            MC_ISSUE = tbl[i].iss; MC_ISSUE_A = tbl[i].ia;
            Q1_A = tbl[i].q1; Q2_A = 4'd15;
            #1;
            chk($sformatf("v%0d_we3", i),   WE3,       tbl[i].e_we);
            chk($sformatf("v%0d_a3", i),    A3,        tbl[i].e_a);
            chk($sformatf("v%0d_wd3", i),   WD3,       tbl[i].e_d);
            chk($sformatf("v%0d_ready", i), MC_READY,  tbl[i].e_rdy);
            chk($sformatf("v%0d_haz1", i),  HAZ1,      tbl[i].e_haz);
            chk($sformatf("v%0d_stall", i), STALL_REQ, tbl[i].e_stall);
            chk($sformatf("v%0d_pend", i),  PEND,      tbl[i].e_pend);
            chk($sformatf("v%0d_err", i),   ERR,       tbl[i].e_err);
            tick();
        end

        // Starvation: head commits once writeback backs off, counter clears.
        build_stall(1'b0);
        chk("starve_we3", WE3, 1'b1);
        chk("starve_a3",  A3,  4'd1);
        tick();
        idle_inputs();
        #1;
        chk("starve_clear", STALL_REQ, 1'b0);
        chk("starve_ready", MC_READY,  1'b1);
        chk("starve_err",   ERR,       1'b0);
        repeat (5) tick();

        // Entry addressed to R15 is dropped without a write and flags ERR.
        MC_VALID = 1; MC_A = 4'd15; MC_WD = 32'hBAD;
        tick();
        idle_inputs();
        #1;
        chk("r15_no_we3", WE3, 1'b0);
        tick();
        #1;
        chk("r15_err", ERR, 1'b1);
        repeat (3) tick();
        chk("r15_sticky", ERR, 1'b1);
        do_reset();

        // Issue to an already-pending register.
        MC_ISSUE = 1; MC_ISSUE_A = 4'd4;
        tick();
        #1;
        chk("dup_first_err", ERR, 1'b0);
        tick();
        MC_ISSUE = 0;
        #1;
        chk("dup_err",  ERR,  1'b1);
        chk("dup_pend", PEND, 15'h0010);
        tick();
        do_reset();

        // Writeback asserted during STALL_REQ still wins, sets ERR.
        build_stall(1'b1);
        chk("stallwb_we3", WE3, 1'b1);
        chk("stallwb_a3",  A3,  4'd8);
        tick();
        #1;
        chk("stallwb_err",   ERR,       1'b1);
        chk("stallwb_stall", STALL_REQ, 1'b1);
        tick();
        do_reset();

        // Asynchronous reset with entries queued and writeback active.
        for (int k = 0; k < 3; k++) begin
            idle_inputs();
            WB_WE = 1; WB_A = 4'd6; WB_WD = 32'h60 + 32'(k);
            MC_VALID = 1; MC_A = 4'(k + 10); MC_WD = 32'hC0 + 32'(k);
            MC_ISSUE = 1; MC_ISSUE_A = 4'(k);
            tick();
        end
        idle_inputs();
        WB_WE = 1; WB_A = 4'd6; WB_WD = 32'h66;
        #1;
        chk("pre_rst_we3", WE3, 1'b1);
        RESETn = 1'b0;
        #1;
        chk("async_we3",   WE3,      1'b0);
        chk("async_pend",  PEND,     15'h0);
        chk("async_ready", MC_READY, 1'b0);
        model_reset();
        @(negedge CLK);
        RESETn = 1'b1;
        WB_WE = 0;
        #1;
        chk("post_rst_ready", MC_READY, 1'b1);
        chk("post_rst_we3",   WE3,      1'b0);
        tick();

        // Random traffic against the model, with periodic resets.
        for (int n = 0; n < 800; n++) begin
            if (n % 200 == 199) do_reset();
            WB_WE      = ($urandom_range(0, 99) < 55);
            WB_A       = 4'($urandom);
            WB_WD      = $urandom;
            MC_VALID   = ($urandom_range(0, 99) < 50);
            MC_A       = ($urandom_range(0, 19) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            MC_WD      = $urandom;
            MC_ISSUE   = ($urandom_range(0, 99) < 20);
            MC_ISSUE_A = 4'($urandom);
            Q1_A       = 4'($urandom);
            Q2_A       = 4'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
